ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
- AHB-Lite slave that converts single AHB transfers into APB4 accesses for a peripheral sub-bus.
- Sits directly downstream of one bus-matrix output port: HSEL/HADDR/HTRANS/HWRITE/HSIZE/HPROT/HWDATA come from the matrix, and HREADY is that port's HREADYMUX output.
- Returns HRDATA/HREADYOUT/HRESP to the matrix.
- One APB transfer is in flight at a time; wait states are inserted on AHB until it completes.

Parameters:
ADDR_WIDTH, 16, width of PADDR; HADDR[ADDR_WIDTH-1:0] is forwarded, upper bits are ignored.
TIMEOUT, 0, PREADY timeout in cycles (1..255); 0 disables the timeout.

Ports:
HCLK  in  1  system clock, rising edge
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select from matrix
HADDR  in  32  address
HTRANS  in  2  transfer type; only bit 1 is used (NONSEQ/SEQ = valid)
HWRITE  in  1  direction
HSIZE  in  3  size
HPROT  in  4  protection
HWDATA  in  32  write data (data phase)
HREADY  in  1  HREADYMUX from matrix
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PSTRB  out  4  APB byte strobes
PPROT  out  3  APB protection
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Clock and reset: one clock (HCLK); reset (HRESETn) is asynchronous and active-low.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, timeout counter=0.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled in IDLE, DONE or ERR2. On accept, register the address, HWRITE, HSIZE and HPROT.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. Accept with HSIZE>2 -> ERR1. Accept otherwise -> LATCH. No accept -> stay.
  - LATCH (first data-phase cycle): HREADYOUT=0, PSEL=0. Capture HWDATA into PWDATA (write) or hold (read). Drive PADDR, PWRITE. PPROT = {~HPROT[0], 1'b0, HPROT[1]}. PSTRB from size and address bits [1:0] on writes: byte -> 1<<a; half -> 3<<(a[1]*2); word -> 4'hF; reads -> 0. Next state SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0 -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. All APB outputs held stable.
    - PREADY & ~PSLVERR: HRDATA <= PRDATA (reads only), go to DONE.
    - PREADY & PSLVERR: go to ERR1.
    - ~PREADY: counter increments; if TIMEOUT!=0 and counter==TIMEOUT-1, go to ERR1 (PSEL dropped).
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accept -> LATCH (or ERR1 if HSIZE>2). Else -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept behaves as in DONE. Else -> IDLE.
- Counter clears on leaving ACCESS.
- Latency: a zero-wait APB slave gives 3 AHB wait states (LATCH, SETUP, ACCESS) plus the DONE cycle. Back-to-back transfers issue with no extra idle cycle.
- PSEL and PENABLE fall together on leaving ACCESS. PADDR, PWRITE, PWDATA and PSTRB hold their last values while idle.
- HRDATA holds its last read value.
- Accept is ignored in LATCH, SETUP, ACCESS and ERR1; the HREADY low time guarantees the master holds its next address.
- Reset mid-transfer: all outputs return to reset values immediately; no APB completion is required.

Test Plan:
- Word write to 0x0000_0104 with HWDATA=0xDEADBEEF, zero-wait APB -> PADDR=0x0104, PWRITE=1, PWDATA=0xDEADBEEF, PSTRB=4'hF; PSEL for 2 cycles, PENABLE in the 2nd; HREADYOUT low for exactly 3 cycles, HRESP=0.
- Byte write at address offset 2, then half-word write at offset 2 -> PSTRB=4'b0100, then 4'b1100. Read -> PSTRB=0.
- Read with PREADY held low 4 cycles, PRDATA=0x12345678 -> ACCESS lasts 5 cycles, HREADYOUT low for 7, HRDATA=0x12345678 in the DONE cycle.
- PSLVERR=1 with PREADY -> two-cycle error: (HREADYOUT=0, HRESP=1) then (HREADYOUT=1, HRESP=1); next NONSEQ accepted in ERR2.
- TIMEOUT=8 with PREADY stuck low -> PSEL drops after 8 ACCESS cycles, ERROR response follows. HSIZE=3 access -> ERROR response with PSEL never asserted.
- Back-to-back NONSEQ write then read; HRESETn pulsed low during ACCESS -> PSEL, PENABLE=0 and HREADYOUT=1 asynchronously; the next transfer completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB transfer in flight, AHB stalled until it
// completes; optional PREADY timeout turns a hung peripheral into an ERROR response.
module ahb_apb_bridge #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [2:0] {
        StIdle, StLatch, StSetup, StAccess, StDone, StErr1, StErr2
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [31:0]           pwdata_q;
    logic [3:0]            pstrb_q;
    logic [2:0]            pprot_q;
    logic [31:0]           hrdata_q;

    logic       accept;
    logic       size_err;
    logic       timeout_hit;
    logic [3:0] strb;
    logic       unused_inputs;

    assign unused_inputs = ^{HADDR, HTRANS[0], HPROT[3:2]};

    assign accept = HSEL & HTRANS[1] & HREADY &
                    ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr2));
    assign size_err    = HSIZE > 3'd2;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

    always_comb begin
        strb = 4'h0;
        if (HWRITE) begin
            case (HSIZE[1:0])
                2'd0:    strb = 4'b0001 << HADDR[1:0];
                2'd1:    strb = HADDR[1] ? 4'b1100 : 4'b0011;
                default: strb = 4'hF;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        case (state_q)
            StIdle, StDone, StErr2: begin
                if (accept) state_d = size_err ? StErr1 : StLatch;
                else        state_d = StIdle;
            end
            StLatch: state_d = StSetup;
            StSetup: state_d = StAccess;
            StAccess: begin
                if (PREADY)           state_d = PSLVERR ? StErr1 : StDone;
                else if (timeout_hit) state_d = StErr1;
                else                  cnt_d   = cnt_q + 8'd1;
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // APB address-side fields are only loaded for legal sizes so they hold across errors.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pstrb_q  <= 4'h0;
            pprot_q  <= 3'b000;
            pwdata_q <= 32'h0;
            hrdata_q <= 32'h0;
        end else begin
            if (accept && !size_err) begin
                paddr_q  <= HADDR[ADDR_WIDTH-1:0];
                pwrite_q <= HWRITE;
                pstrb_q  <= strb;
                pprot_q  <= {~HPROT[0], 1'b0, HPROT[1]};
            end
            if (state_q == StLatch && pwrite_q) begin
                pwdata_q <= HWDATA;
            end
            if (state_q == StAccess && PREADY && !PSLVERR && !pwrite_q) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    assign HREADYOUT = (state_q == StIdle) | (state_q == StDone) | (state_q == StErr2);
    assign HRESP     = (state_q == StErr1) | (state_q == StErr2);
    assign PSEL      = (state_q == StSetup) | (state_q == StAccess);
    assign PENABLE   = (state_q == StAccess);
    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: table of single transfers plus hand-written
// back-to-back and asynchronous-reset sequences.
module tb_ahb_apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [3:0]  HPROT = 4'h0;
    logic [31:0] HWDATA = 32'h0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [15:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int          tests = 0;
    int          failed = 0;

    // APB slave model: ready after apb_wait not-ready ACCESS cycles.
    int          apb_wait = 0;
    logic        apb_err = 1'b0;
    logic [31:0] apb_rdata = 32'h0;
    int          acc_q = 0;

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) acc_q <= (PSEL && PENABLE) ? acc_q + 1 : 0;

    assign PREADY  = PSEL && PENABLE && (acc_q >= apb_wait);
    assign PSLVERR = PREADY && apb_err;
    assign PRDATA  = apb_rdata;
    assign HREADY  = HREADYOUT;

    ahb_apb_bridge #(
        .ADDR_WIDTH(16),
        .TIMEOUT   (8)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HPROT    (HPROT),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PPROT    (PPROT),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  prot;
        logic [31:0] wdata;
        int          wait_n;
        logic        err;
        logic [31:0] rdata;
        logic [15:0] e_paddr;
        logic [3:0]  e_strb;
        logic [2:0]  e_prot;
        int          e_waits;
        int          e_psel;
        logic        e_resp;
        logic [31:0] e_hrdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   waits;
        int   psel_n;
        logic last_resp;
        logic seen;
        logic done;
        waits = 0;
        psel_n = 0;
        last_resp = 1'b0;
        seen = 1'b0;
        done = 1'b0;
        apb_wait  = v.wait_n;
        apb_err   = v.err;
        apb_rdata = v.rdata;
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = v.addr;
        HWRITE = v.wr;
        HSIZE = v.size;
        HPROT = v.prot;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HWDATA = v.wdata;
        for (int c = 0; c < 100; c++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                done = 1'b1;
                break;
            end
            waits++;
            last_resp = HRESP;
            if (PSEL) psel_n++;
            if (PSEL && PENABLE && !seen) begin
                seen = 1'b1;
                check({tag, " paddr"}, 32'(PADDR), 32'(v.e_paddr));
                check({tag, " pwrite"}, 32'(PWRITE), 32'(v.wr));
                check({tag, " pstrb"}, 32'(PSTRB), 32'(v.e_strb));
                check({tag, " pprot"}, 32'(PPROT), 32'(v.e_prot));
                if (v.wr) check({tag, " pwdata"}, PWDATA, v.wdata);
            end
        end
        if (!done) begin
            check({tag, " hreadyout timeout"}, 32'(HREADYOUT), 32'd1);
        end else begin
            check({tag, " wait states"}, 32'(waits), 32'(v.e_waits));
            check({tag, " psel cycles"}, 32'(psel_n), 32'(v.e_psel));
            check({tag, " hresp last wait"}, 32'(last_resp), 32'(v.e_resp));
            check({tag, " hresp"}, 32'(HRESP), 32'(v.e_resp));
            check({tag, " hrdata"}, HRDATA, v.e_hrdata);
        end
    endtask

    initial begin
        int   n;
        logic ok;
        vec_t post;

        //        wr    size  addr          prot     wdata         wt   err   rdata
        //        paddr     strb     prot    waits psel resp hrdata
        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0104, 4'b0011, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,
                     16'h0104, 4'hF, 3'b001, 3, 2, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 3'd0, 32'h0000_0002, 4'b0000, 32'h00AA_0000, 0, 1'b0, 32'h0,
                     16'h0002, 4'b0100, 3'b100, 3, 2, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 3'd1, 32'h0000_0002, 4'b0010, 32'hBEEF_0000, 0, 1'b0, 32'h0,
                     16'h0002, 4'b1100, 3'b101, 3, 2, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'd2, 32'h0000_0200, 4'b0001, 32'h0, 0, 1'b0, 32'hCAFE_F00D,
                     16'h0200, 4'h0, 3'b000, 3, 2, 1'b0, 32'hCAFE_F00D};
        vecs[4]  = '{1'b0, 3'd2, 32'h0000_0010, 4'b0011, 32'h0, 4, 1'b0, 32'h1234_5678,
                     16'h0010, 4'h0, 3'b001, 7, 6, 1'b0, 32'h1234_5678};
        vecs[5]  = '{1'b1, 3'd0, 32'hFFFF_0007, 4'b0001, 32'h7700_0000, 0, 1'b0, 32'h0,
                     16'h0007, 4'b1000, 3'b000, 3, 2, 1'b0, 32'h1234_5678};
        vecs[6]  = '{1'b1, 3'd1, 32'h0000_0020, 4'b0010, 32'h0000_3344, 0, 1'b0, 32'h0,
                     16'h0020, 4'b0011, 3'b101, 3, 2, 1'b0, 32'h1234_5678};
        vecs[7]  = '{1'b1, 3'd2, 32'h0000_0300, 4'b0000, 32'h0102_0304, 0, 1'b1, 32'h0,
                     16'h0300, 4'hF, 3'b100, 4, 2, 1'b1, 32'h1234_5678};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_0304, 4'b0000, 32'h0, 0, 1'b1, 32'h5555_5555,
                     16'h0304, 4'h0, 3'b100, 4, 2, 1'b1, 32'h1234_5678};
        vecs[9]  = '{1'b1, 3'd2, 32'h0000_0308, 4'b0001, 32'hFEED_FACE, 255, 1'b0, 32'h0,
                     16'h0308, 4'hF, 3'b000, 11, 9, 1'b1, 32'h1234_5678};
        vecs[10] = '{1'b1, 3'd3, 32'h0000_0400, 4'b0000, 32'h0, 0, 1'b0, 32'h0,
                     16'h0000, 4'h0, 3'b000, 1, 0, 1'b1, 32'h1234_5678};
        vecs[11] = '{1'b0, 3'd2, 32'h0001_0204, 4'b0010, 32'h0, 1, 1'b0, 32'h0BAD_C0DE,
                     16'h0204, 4'h0, 3'b101, 4, 3, 1'b0, 32'h0BAD_C0DE};

        // Reset values
        repeat (3) @(negedge HCLK);
        check("rst hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst hresp", 32'(HRESP), 32'd0);
        check("rst hrdata", HRDATA, 32'h0);
        check("rst psel", 32'(PSEL), 32'd0);
        check("rst penable", 32'(PENABLE), 32'd0);
        check("rst pwrite", 32'(PWRITE), 32'd0);
        check("rst paddr", 32'(PADDR), 32'd0);
        check("rst pwdata", PWDATA, 32'h0);
        check("rst pstrb", 32'(PSTRB), 32'd0);
        check("rst pprot", 32'(PPROT), 32'd0);
        HRESETn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back: read address held during the write's wait states
        apb_wait = 0;
        apb_err = 1'b0;
        apb_rdata = 32'hA5A5_0F0F;
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = 32'h0000_0040;
        HWRITE = 1'b1;
        HSIZE = 3'd2;
        HPROT = 4'h0;
        @(posedge HCLK);
        #1;
        HWDATA = 32'h1111_2222;
        HADDR = 32'h0000_0044;
        HWRITE = 1'b0;
        n = 0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        check("b2b write ready", 32'(ok), 32'd1);
        check("b2b write waits", 32'(n), 32'd3);
        check("b2b pwdata", PWDATA, 32'h1111_2222);
        @(posedge HCLK);
        #1;
        HSEL = 1'b0;
        HTRANS = 2'b00;
        @(negedge HCLK);
        check("b2b latch hreadyout", 32'(HREADYOUT), 32'd0);
        check("b2b latch psel", 32'(PSEL), 32'd0);
        check("b2b latch paddr", 32'(PADDR), 32'h44);
        check("b2b latch pwrite", 32'(PWRITE), 32'd0);
        @(negedge HCLK);
        check("b2b setup psel", 32'(PSEL), 32'd1);
        check("b2b setup penable", 32'(PENABLE), 32'd0);
        @(negedge HCLK);
        check("b2b access penable", 32'(PENABLE), 32'd1);
        @(negedge HCLK);
        check("b2b read done", 32'(HREADYOUT), 32'd1);
        check("b2b read psel", 32'(PSEL), 32'd0);
        check("b2b read hrdata", HRDATA, 32'hA5A5_0F0F);

        // Asynchronous reset in the middle of ACCESS
        apb_wait = 100;
        @(negedge HCLK);
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HADDR = 32'h0000_0050;
        HWRITE = 1'b0;
        HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0;
        HTRANS = 2'b00;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge HCLK);
            if (PENABLE) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst-mid reached access", 32'(ok), 32'd1);
        HRESETn = 1'b0;
        #1;
        check("rst-mid psel", 32'(PSEL), 32'd0);
        check("rst-mid penable", 32'(PENABLE), 32'd0);
        check("rst-mid hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst-mid hresp", 32'(HRESP), 32'd0);
        check("rst-mid hrdata", HRDATA, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        apb_wait = 0;
        post = vecs[0];
        post.e_hrdata = 32'h0;
        run_vec(post, "post-rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
